// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU result stage:
//   - WORD_SIZE_DEF : default ALU operand/result word width
//   - OP_*          : ALU_Sel opcode constants
//   - z_state_e     : result-stage FSM state type
//   - is_two_word() : true for ops that produce a HI and a LO word (MUL, DIV)
// -----------------------------------------------------------------------------
package alu_pkg;

    localparam int WORD_SIZE_DEF = 32;

    localparam logic [4:0] OP_ADD = 5'd0;
    localparam logic [4:0] OP_SUB = 5'd1;
    localparam logic [4:0] OP_DIV = 5'd2;
    localparam logic [4:0] OP_AND = 5'd3;
    localparam logic [4:0] OP_OR  = 5'd4;
    localparam logic [4:0] OP_XOR = 5'd5;
    localparam logic [4:0] OP_MUL = 5'd6;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DRIVE_LO = 2'd1,
        ST_DRIVE_HI = 2'd2
    } z_state_e;

    // Undefined opcodes fall through to single-word handling.
    function automatic logic is_two_word(input logic [4:0] op);
        return (op == OP_MUL) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/z_reg.sv
// -----------------------------------------------------------------------------
// z_reg
// Enabled word register with asynchronous active-low clear.
// Ports:
//   clk  - rising-edge clock
//   clr  - asynchronous active-low clear (q -> 0)
//   en   - load enable
//   d    - data in (WIDTH bits)
//   q    - registered data out (WIDTH bits)
// -----------------------------------------------------------------------------
module z_reg #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/z_result_stage.sv
// -----------------------------------------------------------------------------
// z_result_stage
// Captures an ALU result and serialises it onto a shared word bus: ZLO first,
// then ZHI for two-word ops (MUL/DIV). MUL/DIV results also update the
// architectural HI/LO registers at acceptance. Counts completed results.
//
// Optional feature: define Z_FLAGS_EN to register zero/negative/carry flags
// at acceptance; otherwise the flag outputs are tied to 0.
//
// Ports:
//   clk          - rising-edge clock
//   clr          - asynchronous active-low reset
//   alu_valid    - ALU result offered
//   alu_ready    - stage can accept (IDLE only)
//   alu_op       - ALU_Sel of the offered result
//   alu_lo       - low word / quotient
//   alu_hi       - high word / remainder
//   carry_in     - ALU CarryOut
//   bus_valid    - bus_data is being driven
//   bus_ready    - bus consumer takes the current word
//   bus_data     - ZLO or ZHI, 0 when idle
//   bus_is_hi    - ZHI is on the bus
//   hi_reg       - architectural HI
//   lo_reg       - architectural LO
//   result_count - completed results, wraps at 256
//   flag_z/n/c   - result flags
//
// state       | meaning
// ------------+--------------------------------------------------
// ST_IDLE     | waiting for a result, alu_ready=1
// ST_DRIVE_LO | ZLO on the bus, waiting for bus_ready
// ST_DRIVE_HI | ZHI on the bus (MUL/DIV only), waiting for bus_ready
// -----------------------------------------------------------------------------
module z_result_stage
    import alu_pkg::*;
#(
    parameter int WORD_SIZE = WORD_SIZE_DEF
) (
    input  logic                 clk,
    input  logic                 clr,
    input  logic                 alu_valid,
    output logic                 alu_ready,
    input  logic [4:0]           alu_op,
    input  logic [WORD_SIZE-1:0] alu_lo,
    input  logic [WORD_SIZE-1:0] alu_hi,
    input  logic                 carry_in,
    output logic                 bus_valid,
    input  logic                 bus_ready,
    output logic [WORD_SIZE-1:0] bus_data,
    output logic                 bus_is_hi,
    output logic [WORD_SIZE-1:0] hi_reg,
    output logic [WORD_SIZE-1:0] lo_reg,
    output logic [7:0]           result_count,
    output logic                 flag_z,
    output logic                 flag_n,
    output logic                 flag_c
);

    z_state_e             state_q, state_d;
    logic [4:0]           op_q;
    logic [7:0]           count_q, count_d;
    logic [WORD_SIZE-1:0] zlo_q, zhi_q;
    logic                 accept;
    logic                 final_hs;
    logic                 arch_load;

    assign accept    = alu_valid & alu_ready;
    assign arch_load = accept & is_two_word(alu_op);

    z_reg #(.WIDTH(WORD_SIZE)) u_zlo (
        .clk (clk), .clr (clr), .en (accept),    .d (alu_lo), .q (zlo_q)
    );
    z_reg #(.WIDTH(WORD_SIZE)) u_zhi (
        .clk (clk), .clr (clr), .en (accept),    .d (alu_hi), .q (zhi_q)
    );
    z_reg #(.WIDTH(WORD_SIZE)) u_hi (
        .clk (clk), .clr (clr), .en (arch_load), .d (alu_hi), .q (hi_reg)
    );
    z_reg #(.WIDTH(WORD_SIZE)) u_lo (
        .clk (clk), .clr (clr), .en (arch_load), .d (alu_lo), .q (lo_reg)
    );

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q <= ST_IDLE;
            op_q    <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            if (accept) begin
                op_q <= alu_op;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        alu_ready = 1'b0;
        bus_valid = 1'b0;
        bus_is_hi = 1'b0;
        bus_data  = '0;
        final_hs  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                alu_ready = 1'b1;
                if (alu_valid) begin
                    state_d = ST_DRIVE_LO;
                end
            end
            ST_DRIVE_LO: begin
                bus_valid = 1'b1;
                bus_data  = zlo_q;
                if (bus_ready) begin
                    if (is_two_word(op_q)) begin
                        state_d = ST_DRIVE_HI;
                    end else begin
                        state_d  = ST_IDLE;
                        final_hs = 1'b1;
                    end
                end
            end
            ST_DRIVE_HI: begin
                bus_valid = 1'b1;
                bus_is_hi = 1'b1;
                bus_data  = zhi_q;
                if (bus_ready) begin
                    state_d  = ST_IDLE;
                    final_hs = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Counter wraps naturally through the 8-bit add.
    always_comb begin
        count_d = count_q;
        if (final_hs) begin
            count_d = count_q + 8'd1;
        end
    end

    assign result_count = count_q;

`ifdef Z_FLAGS_EN
    logic flag_z_q, flag_n_q, flag_c_q;
    logic flag_z_d, flag_n_d;

    // Two-word results judge zero across both words and sign from HI.
    always_comb begin
        flag_z_d = (alu_lo == '0);
        flag_n_d = alu_lo[WORD_SIZE-1];
        if (is_two_word(alu_op)) begin
            flag_z_d = (alu_hi == '0) && (alu_lo == '0);
            flag_n_d = alu_hi[WORD_SIZE-1];
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            flag_z_q <= 1'b0;
            flag_n_q <= 1'b0;
            flag_c_q <= 1'b0;
        end else if (accept) begin
            flag_z_q <= flag_z_d;
            flag_n_q <= flag_n_d;
            flag_c_q <= carry_in;
        end
    end

    assign flag_z = flag_z_q;
    assign flag_n = flag_n_q;
    assign flag_c = flag_c_q;
`else
    logic unused_carry;
    assign unused_carry = carry_in;

    assign flag_z = 1'b0;
    assign flag_n = 1'b0;
    assign flag_c = 1'b0;
`endif

endmodule

// File: doc/z_result_stage.md
Z_RESULT_STAGE -- requirements
Module: z_result_stage

Interface
REQ-001 The block SHALL have parameter WORD_SIZE, default 32, the ALU operand/result word width.
REQ-002 The block SHALL have port clk, input, 1, the single rising-edge clock.
REQ-003 The block SHALL have port clr, input, 1, the asynchronous active-low reset.
REQ-004 The block SHALL have port alu_valid, input, 1, meaning the ALU result is valid.
REQ-005 The block SHALL have port alu_ready, output, 1, meaning the stage can accept a result.
REQ-006 The block SHALL have port alu_op, input, 5, the ALU_Sel code of the offered result.
REQ-007 The block SHALL have port alu_lo, input, WORD_SIZE, the low result word (quotient for DIV).
REQ-008 The block SHALL have port alu_hi, input, WORD_SIZE, the high result word (remainder for DIV).
REQ-009 The block SHALL have port carry_in, input, 1, the ALU CarryOut.
REQ-010 The block SHALL have port bus_valid, output, 1, meaning bus_data is being driven.
REQ-011 The block SHALL have port bus_ready, input, 1, meaning the bus consumer accepts the current word.
REQ-012 The block SHALL have port bus_data, output, WORD_SIZE, carrying ZLO or ZHI.
REQ-013 The block SHALL have port bus_is_hi, output, 1, high while ZHI is driven.
REQ-014 The block SHALL have ports hi_reg and lo_reg, output, WORD_SIZE each, the architectural HI/LO registers.
REQ-015 The block SHALL have port result_count, output, 8, the number of completed results.
REQ-016 The block SHALL have ports flag_z, flag_n and flag_c, output, 1 each, the result flags.

Function
REQ-017 The FSM SHALL have states IDLE, DRIVE_LO and DRIVE_HI.
REQ-018 alu_ready SHALL be 1 only in IDLE; there is no accept during DRIVE_LO or DRIVE_HI, including the final-handshake cycle.
REQ-019 In IDLE, when alu_valid&alu_ready, the block SHALL capture alu_lo->ZLO, alu_hi->ZHI and alu_op, then go to DRIVE_LO.
REQ-020 bus_valid SHALL assert the cycle after acceptance (1-cycle latency), with bus_data=ZLO and bus_is_hi=0.
REQ-021 In DRIVE_LO, on bus_ready, the FSM SHALL go to DRIVE_HI if the captured op is MUL (6) or DIV (2), else to IDLE.
REQ-022 In DRIVE_HI, bus_data SHALL be ZHI with bus_is_hi=1, and on bus_ready the FSM SHALL go to IDLE.
REQ-023 bus_data, ZLO and ZHI SHALL hold stable while bus_valid=1 and bus_ready=0, with no timeout.
REQ-024 On acceptance of MUL or DIV, hi_reg/lo_reg SHALL load alu_hi/alu_lo at the same edge; other ops SHALL leave them unchanged.
REQ-025 Opcodes 0,1,3,4,5 and any undefined code SHALL be treated as single-word results.
REQ-026 result_count SHALL increment by 1 on the final bus handshake of each result and wrap from 255 to 0.
REQ-027 bus_data SHALL be 0 whenever bus_valid=0.

Reset
REQ-028 clr=0 SHALL asynchronously force IDLE; ZLO, ZHI, hi_reg, lo_reg, result_count and flags to 0; bus_valid=0; alu_ready=1 after release.
REQ-029 Reset during DRIVE_LO or DRIVE_HI SHALL abandon the in-flight result without counting it.

Configuration
REQ-030 With macro Z_FLAGS_EN defined, flags SHALL load at acceptance as follows: flag_z = (lo==0) for single-word ops or (hi==0&&lo==0) for MUL/DIV; flag_n = MSB of lo for single-word ops or MSB of hi for MUL/DIV; flag_c = carry_in.
REQ-031 Without Z_FLAGS_EN, flag_z, flag_n and flag_c SHALL be tied to 0, with the ports still present.

Structure
REQ-032 Package alu_pkg SHALL hold WORD_SIZE default, opcode constants (ADD=0, SUB=1, DIV=2, AND=3, OR=4, XOR=5, MUL=6) and the FSM state typedef.
REQ-033 ZLO, ZHI, HI and LO SHALL each be an instance of sub-module z_reg (WORD_SIZE-wide, enable, async active-low clear).

Verification
REQ-034 ADD: alu_op=0, lo=0x00000005, bus_ready=1 -> one beat 0x00000005 with bus_is_hi=0, return to IDLE, result_count=1.
REQ-035 MUL: alu_op=6, hi=0x00000001, lo=0x80000000 -> beats 0x80000000 then 0x00000001 with bus_is_hi=1, hi_reg=1, lo_reg=0x80000000.
REQ-036 Backpressure: DIV with bus_ready=0 for 5 cycles -> bus_data stable, alu_ready=0, second alu_valid ignored.
REQ-037 Reset mid-DRIVE_HI: clr=0 -> bus_valid=0 immediately, result_count unchanged, hi_reg=0.
REQ-038 Wrap: 256 ADD results -> result_count=0.
REQ-039 With Z_FLAGS_EN: SUB result lo=0, carry_in=1 -> flag_z=1, flag_n=0, flag_c=1; without the macro all flags read 0.
